// File: rtl/fix_stream_pkg.sv
// Shared types and default widths for the coefficient-table read streamer.
// The table is 256 x 16 and a transfer can span the whole table (0..256 words).
package fix_stream_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;
   localparam int LEN_W      = DEF_ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/fix_stream_buf.sv
// Small register FIFO carrying {last, data}; entry 0 is the head and drives
// the stream outputs directly from flops.
module fix_stream_buf #(
   parameter  int DATA_W    = 16,
   parameter  int BUF_DEPTH = 2,
   localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              push,
   input  logic              push_last,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [CNT_W-1:0]  count,
   output logic              head_valid,
   output logic              head_last,
   output logic [DATA_W-1:0] head_data
);

   localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   logic [DATA_W:0]   mem     [BUF_DEPTH];
   logic [DATA_W:0]   mem_nxt [BUF_DEPTH];
   logic [CNT_W-1:0]  cnt_nxt;
   logic [IDX_W-1:0]  wr_idx;
   logic              pop_eff;
   logic              push_eff;

   // A push into a full buffer is accepted only when the head leaves in the same cycle.
   always_comb begin
      pop_eff  = pop && (count != '0);
      push_eff = push && ((count != CNT_W'(BUF_DEPTH)) || pop_eff);
      wr_idx   = pop_eff ? IDX_W'(count - CNT_W'(1)) : IDX_W'(count);
      mem_nxt  = mem;
      if (pop_eff) begin
         for (int i = 0; i < BUF_DEPTH - 1; i++) begin
            mem_nxt[i] = mem[i + 1];
         end
      end
      if (push_eff) begin
         mem_nxt[wr_idx] = {push_last, push_data};
      end
      cnt_nxt = count + CNT_W'(push_eff) - CNT_W'(pop_eff);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         count <= '0;
      end else begin
         count <= cnt_nxt;
         mem   <= mem_nxt;
      end
   end

   assign head_valid = (count != '0);
   assign head_last  = head_valid && mem[0][DATA_W];
   assign head_data  = mem[0][DATA_W-1:0];

endmodule

// File: rtl/fix_table_streamer.sv
// Read-side sequencer for the coefficient RAM: issues sequential reads and
// re-emits the returned words as a valid/ready stream with last marking.
module fix_table_streamer
   import fix_stream_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_chipselect,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready
);

   localparam int LEN_BITS = ADDR_W + 1;
   localparam int CNT_W    = $clog2(BUF_DEPTH + 1);
   localparam int CR_W     = CNT_W + 1;

   state_t              state;
   state_t              state_nxt;
   logic                done_nxt;
   logic [ADDR_W-1:0]   ptr;
   logic [LEN_BITS-1:0] issue_cnt;
   logic [LEN_BITS-1:0] beat_cnt;
   logic                in_flight;
   logic                rd_last_p1;
   logic [CNT_W-1:0]    buf_count;
   logic [CR_W-1:0]     credit_used;
   logic                pop;
   logic                push;
   logic                can_issue;
   logic                accept_start;
   logic                last_beat;

   // Credits count the head leaving this cycle so a steady stream issues every cycle.
   assign pop          = out_valid && out_ready;
   assign credit_used  = {1'b0, buf_count} + CR_W'(in_flight) - CR_W'(pop);
   assign can_issue    = (state == ST_RUN) && (issue_cnt != '0)
                         && (credit_used < CR_W'(BUF_DEPTH)) && !abort;
   assign accept_start = (state == ST_IDLE) && start && !abort;
   assign push         = in_flight && !abort;
   assign last_beat    = pop && (beat_cnt == LEN_BITS'(1));

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (length != '0) state_nxt = ST_RUN;
                  else              done_nxt  = 1'b1;
               end
            end
            ST_RUN: begin
               if (can_issue && (issue_cnt == LEN_BITS'(1))) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!in_flight && last_beat) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   // Issue stage: pointer and counters; the read returns one cycle later (_p1).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr        <= '0;
         issue_cnt  <= '0;
         beat_cnt   <= '0;
         in_flight  <= 1'b0;
         rd_last_p1 <= 1'b0;
      end else begin
         in_flight  <= can_issue;
         rd_last_p1 <= can_issue && (issue_cnt == LEN_BITS'(1));
         if (accept_start && (length != '0)) begin
            ptr       <= base_addr;
            issue_cnt <= length;
            beat_cnt  <= length;
         end else if (abort) begin
            issue_cnt <= '0;
            beat_cnt  <= '0;
         end else begin
            if (can_issue) begin
               ptr       <= ptr + ADDR_W'(1);
               issue_cnt <= issue_cnt - LEN_BITS'(1);
            end
            if (pop) begin
               beat_cnt <= beat_cnt - LEN_BITS'(1);
            end
         end
      end
   end

   // Capture stage: returned word enters the output buffer.
   fix_stream_buf #(
      .DATA_W    (DATA_W),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (abort),
      .push       (push),
      .push_last  (rd_last_p1),
      .push_data  (ram_readdata),
      .pop        (pop),
      .count      (buf_count),
      .head_valid (out_valid),
      .head_last  (out_last),
      .head_data  (out_data)
   );

   assign busy           = (state != ST_IDLE);
   assign ram_address    = ptr;
   assign ram_chipselect = can_issue;
   assign ram_clken      = can_issue;

endmodule

// File: tb/tb_fix_table_streamer.sv
// Scoreboard bench for fix_table_streamer with a 1-cycle-latency RAM model
// holding mem[i] = 16'h1000 + i.
module tb_fix_table_streamer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  length;
   logic        abort;
   logic        busy;
   logic        done;
   logic [7:0]  ram_address;
   logic        ram_chipselect;
   logic        ram_clken;
   logic [15:0] ram_readdata;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;

   int errors = 0;
   int checks = 0;
   int beats  = 0;

   logic [16:0] exp_q[$];
   logic [7:0]  addr_q[$];
   bit          mon_en = 1'b0;
   bit          bp_chk = 1'b0;
   int          occ_tb = 0;
   int          infl_tb = 0;
   bit          stall_prev = 1'b0;
   logic [15:0] stall_data = '0;
   logic [7:0]  ram_q_addr = '0;

   always #5 clk = ~clk;

   fix_table_streamer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .base_addr      (base_addr),
      .length         (length),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .ram_address    (ram_address),
      .ram_chipselect (ram_chipselect),
      .ram_clken      (ram_clken),
      .ram_readdata   (ram_readdata),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_last       (out_last),
      .out_ready      (out_ready)
   );

   always @(posedge clk) begin
      if (ram_clken && ram_chipselect) ram_q_addr <= ram_address;
   end
   assign ram_readdata = 16'h1000 + {8'h00, ram_q_addr};

   // Monitor: RAM issue order, stream beats, stall stability, credit limit
   always @(negedge clk) begin
      logic [16:0] e;
      logic [7:0]  ea;
      int          pop_now;
      if (mon_en && reset_n && !abort) begin
         if (ram_clken) begin
            checks++;
            if (addr_q.size() == 0) begin
               errors++;
               $display("FAIL ram_issue: unexpected read at addr %h", ram_address);
            end else begin
               ea = addr_q.pop_front();
               if (ram_address !== ea || ram_chipselect !== 1'b1) begin
                  errors++;
                  $display("FAIL ram_addr: got %h cs=%b expected %h cs=1", ram_address, ram_chipselect, ea);
               end
            end
         end
         if (out_valid && out_ready) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat: unexpected beat data=%h last=%b", out_data, out_last);
            end else begin
               e = exp_q.pop_front();
               if ({out_last, out_data} !== e) begin
                  errors++;
                  $display("FAIL beat: got last=%b data=%h expected last=%b data=%h", out_last, out_data, e[16], e[15:0]);
               end
            end
         end
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== stall_data) begin
               errors++;
               $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, stall_data);
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;
         if (bp_chk) begin
            pop_now = (out_valid && out_ready) ? 1 : 0;
            checks++;
            if ((ram_clken && (occ_tb + infl_tb - pop_now >= 2)) || (out_valid !== (occ_tb != 0))) begin
               errors++;
               $display("FAIL credit: clken=%b valid=%b with occ=%0d inflight=%0d pop=%0d, required no issue at 2 and valid=%b",
                        ram_clken, out_valid, occ_tb, infl_tb, pop_now, (occ_tb != 0));
            end
            occ_tb  = occ_tb + infl_tb - pop_now;
            infl_tb = ram_clken ? 1 : 0;
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input int base, input int len, input bit expect_run);
      logic [16:0] e;
      start     = 1'b1;
      base_addr = 8'(base);
      length    = 9'(len);
      if (expect_run) begin
         for (int i = 0; i < len; i++) begin
            e = {(i == len - 1), 16'(16'h1000 + ((base + i) % 256))};
            exp_q.push_back(e);
            addr_q.push_back(8'((base + i) % 256));
         end
      end
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({busy, done, ram_chipselect, ram_clken, out_valid, out_last} !== 6'b0 ||
          ram_address !== 8'h00 || out_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b cs=%b clken=%b valid=%b last=%b addr=%h data=%h expected all 0",
                  busy, done, ram_chipselect, ram_clken, out_valid, out_last, ram_address, out_data);
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      mon_en = 1'b1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got busy=%b valid=%b expected 0 0", busy, out_valid);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      drive_start(0, 4, 1'b1);
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_start: got busy=%b valid=%b expected busy=1 valid=0", busy, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency_early: got valid=%b expected 0", out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_last !== (i == 3)) begin
            errors++;
            $display("FAIL basic_beat%0d: got valid=%b last=%b expected valid=1 last=%b", i, out_valid, out_last, (i == 3));
         end
      end
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_after: got done=%b pending=%0d expected done=0 pending=0", done, exp_q.size());
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      out_ready = 1'b1;
      drive_start(254, 4, 1'b1);
      while (!done && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1 || exp_q.size() != 0 || addr_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_done: got done=%b pending beats=%0d addrs=%0d expected done=1 and 0 0", done, exp_q.size(), addr_q.size());
      end
      tick();
   endtask

   task automatic test_backpressure();
      int n = 0;
      int b0;
      b0      = beats;
      occ_tb  = 0;
      infl_tb = 0;
      bp_chk  = 1'b1;
      out_ready = 1'b1;
      drive_start(16, 8, 1'b1);
      while (!done && n < 100) begin
         out_ready = (n % 3 == 0);
         tick();
         n++;
      end
      bp_chk = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (done !== 1'b1 || beats - b0 != 8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_done: got done=%b beats=%0d pending=%0d expected done=1 beats=8 pending=0", done, beats - b0, exp_q.size());
      end
      tick();
   endtask

   task automatic test_zero_and_full();
      int n = 0;
      int b0;
      drive_start(7, 0, 1'b0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_len: got done=%b busy=%b valid=%b expected 1 0 0", done, busy, out_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: got done=%b valid=%b expected 0 0", done, out_valid);
         end
      end
      b0 = beats;
      drive_start(0, 256, 1'b1);
      while (!done && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1 || beats - b0 != 256 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL full_table: got done=%b beats=%0d pending=%0d expected done=1 beats=256 pending=0", done, beats - b0, exp_q.size());
      end
      tick();
   endtask

   task automatic test_abort();
      int n = 0;
      int b0;
      out_ready = 1'b1;
      b0 = beats;
      drive_start(0, 10, 1'b1);
      while (beats - b0 < 3 && n < 30) begin
         tick();
         n++;
      end
      abort = 1'b1;
      exp_q.delete();
      addr_q.delete();
      tick();
      abort = 1'b0;
      checks++;
      if (beats - b0 != 3 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort: got beats=%0d valid=%b busy=%b done=%b expected beats=3 valid=0 busy=0 done=0", beats - b0, out_valid, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got done=%b valid=%b expected 0 0", done, out_valid);
         end
      end
      n = 0;
      drive_start(5, 2, 1'b1);
      while (!done && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL abort_restart: got done=%b pending=%0d expected done=1 pending=0", done, exp_q.size());
      end
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive_start(0, 10, 1'b1);
      tick();
      tick();
      tick();
      #2;
      mon_en  = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, ram_chipselect, ram_clken, out_valid, out_last} !== 6'b0 ||
          ram_address !== 8'h00 || out_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b done=%b cs=%b clken=%b valid=%b last=%b addr=%h data=%h expected all 0",
                  busy, done, ram_chipselect, ram_clken, out_valid, out_last, ram_address, out_data);
      end
      exp_q.delete();
      addr_q.delete();
      tick();
      reset_n   = 1'b1;
      out_ready = 1'b1;
      tick();
      mon_en = 1'b1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_release: got busy=%b valid=%b expected 0 0", busy, out_valid);
      end
   endtask

   task automatic test_ignored();
      int n = 0;
      int b0;
      out_ready = 1'b1;
      b0 = beats;
      drive_start(32, 6, 1'b1);
      tick();
      drive_start(100, 3, 1'b0);
      while (!done && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1 || beats - b0 != 6 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL start_busy: got done=%b beats=%0d pending=%0d expected done=1 beats=6 pending=0", done, beats - b0, exp_q.size());
      end
      tick();
      start = 1'b1;
      abort = 1'b1;
      base_addr = 8'h40;
      length = 9'd4;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL start_abort: got busy=%b done=%b expected 0 0", busy, done);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_quiet: got valid=%b busy=%b expected 0 0", out_valid, busy);
         end
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      abort     = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_and_full();
      test_abort();
      test_reset_mid();
      test_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
